// File: rtl/k005297_dmawordseq_pkg.sv
// rtl/k005297_dmawordseq_pkg.sv - shared types and constants for the DMA word sequencer
//
// Purpose: sequencer state encoding, acquisition mode codes, lane index width helper.
// Ports:   none (package).
package k005297_dmawordseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [1:0] MODE_USER = 2'b00;
    localparam logic [1:0] MODE_BOOT = 2'b01;
    localparam logic [1:0] MODE_INIT = 2'b10;

    function automatic int lidx_w(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/k005297_dlcnt_sat.sv
// rtl/k005297_dlcnt_sat.sv - saturating down-counter with load and registered zero flag
//
// Purpose: bootloader byte counter; load beats decrement, decrement stops at zero.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset (count 0, zero flag 1)
//   ce_i      clock enable; state advances only when 1
//   ld_i      load ld_val_i
//   ld_val_i  load value
//   dec_i     decrement request
//   cnt_o     current count
//   zero_o    cnt_o == 0
module k005297_dlcnt_sat #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // The zero flag is registered alongside the count so both change on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else if (ce_i) begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/k005297_dmawordseq.sv
// rtl/k005297_dmawordseq.sv - assembles bubble bytes into LANES-byte DMA words
//
// Purpose: per accepted byte, pulse a one-hot lane load strobe and signal word
// completion; user-page, bootloader byte-count and init (header skip) modes.
// Ports:
//   i_MCLK          master clock
//   i_SYS_RST       asynchronous active-high reset
//   i_CLK2M_PCEN_n  active-low clock enable
//   i_MODE          00 user, 01 bootloader, 10 init, 11 treated as user
//   i_ACQ_START     start acquisition (IDLE only)
//   i_BYTE_VALID    byte ready from the acquisition shifter
//   i_PAGE_VALID    gates bytes in user mode
//   i_DLCNT_LD      load bootloader counter with i_DLCNT_INIT
//   i_DLCNT_INIT    counter load value
//   i_WORD_END      forces the lane index to 0
//   i_ABORT         abandon acquisition
//   o_NEWBYTE       byte accepted strobe
//   o_LANE_LD       one-hot lane load strobe
//   o_WORD_DONE     word complete or partial word flushed
//   o_DLCNT         bootloader counter
//   o_DLCNT_ZERO    o_DLCNT == 0
//   o_BUSY          sequencer not idle
module k005297_dmawordseq
    import k005297_dmawordseq_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int DLCNT_W = 12
) (
    input  logic               i_MCLK,
    input  logic               i_SYS_RST,
    input  logic               i_CLK2M_PCEN_n,
    input  logic [1:0]         i_MODE,
    input  logic               i_ACQ_START,
    input  logic               i_BYTE_VALID,
    input  logic               i_PAGE_VALID,
    input  logic               i_DLCNT_LD,
    input  logic [DLCNT_W-1:0] i_DLCNT_INIT,
    input  logic               i_WORD_END,
    input  logic               i_ABORT,
    output logic               o_NEWBYTE,
    output logic [LANES-1:0]   o_LANE_LD,
    output logic               o_WORD_DONE,
    output logic [DLCNT_W-1:0] o_DLCNT,
    output logic               o_DLCNT_ZERO,
    output logic               o_BUSY
);

    localparam int               LW       = lidx_w(LANES);
    localparam logic [LW-1:0]    LAST_IDX = LW'(LANES - 1);
    localparam logic [LANES-1:0] LANE_ONE = {{(LANES-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic             newbyte_q, newbyte_d;
    logic [LANES-1:0] lane_ld_q, lane_ld_d;
    logic             word_done_q, word_done_d;

    logic               en;
    logic [1:0]         mode_eff;
    logic               byte_ok;
    logic               take;
    logic               dec;
    logic [DLCNT_W-1:0] dlcnt;
    logic               dlcnt_zero;

    assign en       = ~i_CLK2M_PCEN_n;
    assign mode_eff = (i_MODE == 2'b11) ? MODE_USER : i_MODE;
    assign byte_ok  = i_BYTE_VALID & ((mode_eff != MODE_USER) | i_PAGE_VALID);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        newbyte_d   = 1'b0;
        lane_ld_d   = '0;
        word_done_d = 1'b0;
        take        = 1'b0;
        dec         = 1'b0;

        if (i_ABORT) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_ACQ_START) begin
                        state_d = PRIME;
                        idx_d   = '0;
                    end
                end
                PRIME: begin
                    // An empty bootloader count means there is nothing to fetch.
                    if ((mode_eff == MODE_BOOT) && dlcnt_zero) begin
                        state_d = DRAIN;
                    end else if (byte_ok) begin
                        state_d = RUN;
                        if (mode_eff == MODE_INIT) begin
                            newbyte_d = 1'b1;   // header byte: acknowledged, not stored
                        end else begin
                            take = 1'b1;
                        end
                    end
                end
                RUN: begin
                    take = byte_ok;
                end
                DRAIN: begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    word_done_d = (idx_q != '0);
                end
            endcase

            if (take) begin
                newbyte_d = 1'b1;
                lane_ld_d = LANE_ONE << idx_q;
                if (idx_q == LAST_IDX) begin
                    word_done_d = 1'b1;
                    idx_d       = '0;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
                if (mode_eff == MODE_BOOT) begin
                    dec = 1'b1;
                    // Last counted byte; a same-cycle reload keeps the counter alive.
                    if ((dlcnt <= DLCNT_W'(1)) && !i_DLCNT_LD) begin
                        state_d = DRAIN;
                    end
                end
            end

            if (i_WORD_END) begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
        if (i_SYS_RST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            newbyte_q   <= 1'b0;
            lane_ld_q   <= '0;
            word_done_q <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            newbyte_q   <= newbyte_d;
            lane_ld_q   <= lane_ld_d;
            word_done_q <= word_done_d;
        end
    end

    k005297_dlcnt_sat #(
        .W(DLCNT_W)
    ) u_dlcnt (
        .clk_i    (i_MCLK),
        .rst_i    (i_SYS_RST),
        .ce_i     (en),
        .ld_i     (i_DLCNT_LD),
        .ld_val_i (i_DLCNT_INIT),
        .dec_i    (dec),
        .cnt_o    (dlcnt),
        .zero_o   (dlcnt_zero)
    );

    assign o_NEWBYTE    = newbyte_q;
    assign o_LANE_LD    = lane_ld_q;
    assign o_WORD_DONE  = word_done_q;
    assign o_DLCNT      = dlcnt;
    assign o_DLCNT_ZERO = dlcnt_zero;
    assign o_BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_k005297_dmawordseq.sv
// tb/tb_k005297_dmawordseq.sv - self-checking bench for k005297_dmawordseq (LANES=2 and LANES=4)
module tb_k005297_dmawordseq;

    logic        clk = 1'b0;
    logic        rst, pcen_n, acq_start, byte_valid, page_valid, dlcnt_ld, word_end, abort_i;
    logic [1:0]  mode;
    logic [11:0] dlcnt_init;

    logic        nb2, wd2, z2, busy2, nb4, wd4, z4, busy4;
    logic [1:0]  ld2;
    logic [3:0]  ld4;
    logic [11:0] cnt2, cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, phase (0 idle,1 waiting first byte,2 running,3 flush),
    // bytes held in the current word, counter and last strobes.
    int         lanes_of[2] = '{2, 4};
    int         m_ph[2], m_fill[2], m_cnt[2];
    logic       m_nb[2], m_wd[2];
    logic [7:0] m_ld[2];

    always #5 clk = ~clk;

    k005297_dmawordseq #(.LANES(2), .DLCNT_W(12)) u_l2 (
        .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_MODE(mode),
        .i_ACQ_START(acq_start), .i_BYTE_VALID(byte_valid), .i_PAGE_VALID(page_valid),
        .i_DLCNT_LD(dlcnt_ld), .i_DLCNT_INIT(dlcnt_init), .i_WORD_END(word_end), .i_ABORT(abort_i),
        .o_NEWBYTE(nb2), .o_LANE_LD(ld2), .o_WORD_DONE(wd2), .o_DLCNT(cnt2),
        .o_DLCNT_ZERO(z2), .o_BUSY(busy2));

    k005297_dmawordseq #(.LANES(4), .DLCNT_W(12)) u_l4 (
        .i_MCLK(clk), .i_SYS_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_MODE(mode),
        .i_ACQ_START(acq_start), .i_BYTE_VALID(byte_valid), .i_PAGE_VALID(page_valid),
        .i_DLCNT_LD(dlcnt_ld), .i_DLCNT_INIT(dlcnt_init), .i_WORD_END(word_end), .i_ABORT(abort_i),
        .o_NEWBYTE(nb4), .o_LANE_LD(ld4), .o_WORD_DONE(wd4), .o_DLCNT(cnt4),
        .o_DLCNT_ZERO(z4), .o_BUSY(busy4));

    function automatic logic [23:0] obs_vec(input int i);
        if (i == 0) return {nb2, wd2, busy2, z2, 6'b0, ld2, cnt2};
        return {nb4, wd4, busy4, z4, 4'b0, ld4, cnt4};
    endfunction

    function automatic logic [23:0] exp_vec(input int i);
        return {m_nb[i], m_wd[i], (m_ph[i] != 0), (m_cnt[i] == 0), m_ld[i], 12'(m_cnt[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
            m_nb[i] = 1'b0; m_wd[i] = 1'b0; m_ld[i] = 8'd0;
        end
    endtask

    task automatic model_step();
        int  em, nph, nfill, ncnt;
        bit  acc, take;
        if (!pcen_n) begin
            em  = (mode == 2'b11) ? 0 : int'(mode);
            acc = byte_valid && (em != 0 || page_valid);
            for (int i = 0; i < 2; i++) begin
                m_nb[i] = 1'b0; m_wd[i] = 1'b0; m_ld[i] = 8'd0;
                take = 0; nph = m_ph[i]; nfill = m_fill[i]; ncnt = m_cnt[i];
                if (abort_i) begin
                    nph = 0; nfill = 0;
                end else begin
                    case (m_ph[i])
                        0: if (acq_start) begin nph = 1; nfill = 0; end
                        1: if (em == 1 && m_cnt[i] == 0) nph = 3;
                           else if (acc) begin
                               nph = 2;
                               if (em == 2) m_nb[i] = 1'b1; else take = 1;
                           end
                        2: take = acc;
                        default: begin
                            m_wd[i] = (m_fill[i] != 0);
                            nfill = 0; nph = 0;
                        end
                    endcase
                    if (take) begin
                        m_nb[i] = 1'b1;
                        m_ld[i] = 8'd1 << m_fill[i];
                        nfill   = m_fill[i] + 1;
                        if (nfill == lanes_of[i]) begin m_wd[i] = 1'b1; nfill = 0; end
                        if (em == 1) begin
                            if (m_cnt[i] > 0) ncnt = m_cnt[i] - 1;
                            if (ncnt == 0 && !dlcnt_ld) nph = 3;
                        end
                    end
                    if (word_end) nfill = 0;
                end
                if (dlcnt_ld) ncnt = int'(dlcnt_init);
                m_ph[i] = nph; m_fill[i] = nfill; m_cnt[i] = ncnt;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic idle_inputs();
        acq_start = 0; byte_valid = 0; page_valid = 0; dlcnt_ld = 0;
        dlcnt_init = 12'd0; word_end = 0; abort_i = 0; pcen_n = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        mode = 2'b00;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        mode = 2'b00;
        rst = 1;
        model_reset();
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++; $display("FAIL reset[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
        n_checks++;
        if ({busy4, z4, nb4, wd4, ld4} !== 8'b0100_0000) begin
            n_fail++; $display("FAIL reset_direct got %b want 01000000", {busy4, z4, nb4, wd4, ld4});
        end
        rst = 0;
    endtask

    task automatic test_user_l2();
        logic [1:0] exp_ld[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset_dut();
        acq_start = 1; tick(); acq_start = 0;
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1; page_valid = 1; tick();
            n_checks++;
            if ({nb2, ld2, wd2} !== {1'b1, exp_ld[k], (k % 2 == 1)}) begin
                n_fail++; $display("FAIL user_l2 byte%0d got %b want %b", k, {nb2, ld2, wd2}, {1'b1, exp_ld[k], (k % 2 == 1)});
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL user_l2 model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        byte_valid = 0; tick();
        n_checks++;
        if ({nb2, ld2, wd2} !== 4'b0000) begin
            n_fail++; $display("FAIL user_l2 strobe_clear got %b want 0000", {nb2, ld2, wd2});
        end
    endtask

    task automatic test_init_l4();
        logic [3:0] exp_ld[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset_dut();
        mode = 2'b10;
        acq_start = 1; tick(); acq_start = 0;
        for (int k = 0; k < 5; k++) begin
            byte_valid = 1; tick();
            n_checks++;
            if ({nb4, ld4, wd4} !== {1'b1, exp_ld[k], (k == 4)}) begin
                n_fail++; $display("FAIL init_l4 byte%0d got %b want %b", k, {nb4, ld4, wd4}, {1'b1, exp_ld[k], (k == 4)});
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL init_l4 model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        byte_valid = 0;
    endtask

    task automatic test_boot();
        logic [3:0] exp_ld[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        reset_dut();
        mode = 2'b01;
        dlcnt_ld = 1; dlcnt_init = 12'd6; tick(); dlcnt_ld = 0;
        acq_start = 1; tick(); acq_start = 0;
        for (int k = 0; k < 6; k++) begin
            byte_valid = 1; tick();
            n_checks++;
            if ({ld4, wd4, cnt4} !== {exp_ld[k], (k == 3), 12'(5 - k)}) begin
                n_fail++; $display("FAIL boot byte%0d got %h want %h", k, {ld4, wd4, cnt4}, {exp_ld[k], (k == 3), 12'(5 - k)});
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL boot model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        byte_valid = 0;
        tick();
        n_checks++;
        if ({wd4, nb4, busy4} !== 3'b100) begin
            n_fail++; $display("FAIL boot flush got %b want 100", {wd4, nb4, busy4});
        end
        tick();
        n_checks++;
        if ({wd4, busy4, z4, cnt4} !== {3'b001, 12'd0}) begin
            n_fail++; $display("FAIL boot after got %h want %h", {wd4, busy4, z4, cnt4}, {3'b001, 12'd0});
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++; $display("FAIL boot end model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_page_gate();
        logic [3:0] exp[4] = '{4'b1010, 4'b0000, 4'b1101, 4'b0000}; // {nb, ld2, wd2}
        reset_dut();
        acq_start = 1; tick(); acq_start = 0;
        for (int k = 0; k < 4; k++) begin
            byte_valid = 1; page_valid = (k % 2 == 0); tick();
            n_checks++;
            if ({nb2, ld2, wd2} !== exp[k]) begin
                n_fail++; $display("FAIL page_gate byte%0d got %b want %b", k, {nb2, ld2, wd2}, exp[k]);
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL page_gate model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        byte_valid = 0; page_valid = 0;
    endtask

    task automatic test_word_end_abort();
        reset_dut();
        acq_start = 1; tick(); acq_start = 0;
        byte_valid = 1; page_valid = 1; word_end = 1; tick(); word_end = 0;
        n_checks++;
        if ({nb4, ld4, wd4} !== 6'b100010) begin
            n_fail++; $display("FAIL word_end_byte got %b want 100010", {nb4, ld4, wd4});
        end
        tick();
        n_checks++;
        if ({nb4, ld4, wd4} !== 6'b100010) begin
            n_fail++; $display("FAIL word_end_next got %b want 100010", {nb4, ld4, wd4});
        end
        abort_i = 1; tick(); abort_i = 0; byte_valid = 0;
        n_checks++;
        if ({nb4, ld4, wd4, busy4} !== 7'b0) begin
            n_fail++; $display("FAIL abort got %b want 0000000", {nb4, ld4, wd4, busy4});
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++; $display("FAIL abort model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_hold_async_reset();
        reset_dut();
        acq_start = 1; tick(); acq_start = 0;
        byte_valid = 1; page_valid = 1; tick();
        pcen_n = 1;
        for (int k = 0; k < 3; k++) begin
            dlcnt_ld = 1; dlcnt_init = 12'($urandom_range(1, 4095)); word_end = k[0];
            tick();
            n_checks++;
            if ({nb4, ld4, wd4, busy4, cnt4} !== {6'b100010, 1'b1, 12'd0}) begin
                n_fail++; $display("FAIL hold cyc%0d got %h want %h", k, {nb4, ld4, wd4, busy4, cnt4}, {6'b100010, 1'b1, 12'd0});
            end
        end
        dlcnt_ld = 0; word_end = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        if ({nb4, ld4, wd4, busy4, z4, nb2, wd2, busy2, z2} !== 12'b0000_0001_0001) begin
            n_fail++; $display("FAIL async_reset got %b want 000000010001", {nb4, ld4, wd4, busy4, z4, nb2, wd2, busy2, z2});
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                n_fail++; $display("FAIL async_reset model[%0d] got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
        rst = 0; pcen_n = 0; byte_valid = 0;
    endtask

    task automatic test_random();
        reset_dut();
        for (int k = 0; k < 800; k++) begin
            pcen_n     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            acq_start  = ($urandom_range(0, 3) == 0);
            byte_valid = $urandom_range(0, 1);
            page_valid = ($urandom_range(0, 3) != 0);
            dlcnt_ld   = ($urandom_range(0, 15) == 0);
            dlcnt_init = 12'($urandom_range(0, 9));
            word_end   = ($urandom_range(0, 11) == 0);
            abort_i    = ($urandom_range(0, 24) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    n_fail++; $display("FAIL random cyc%0d dut%0d got %h want %h", k, i, obs_vec(i), exp_vec(i));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_user_l2();
        test_init_l4();
        test_boot();
        test_page_gate();
        test_word_end_abort();
        test_hold_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
